// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and request-fault helpers for the load/store unit.
package lsu_pkg;

  localparam int XLEN       = 64;
  localparam int BYTE_OFF_W = 3;
  localparam int NBYTES     = XLEN / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} lsu_state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} mem_size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  function automatic logic is_misaligned(mem_size_e size, logic [BYTE_OFF_W-1:0] off);
    logic r;
    case (size)
      SZ_B:    r = 1'b0;
      SZ_H:    r = off[0];
      SZ_W:    r = |off[1:0];
      SZ_D:    r = |off;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // The unsigned bit has no meaning for stores, so it is treated as an illegal encoding there.
  function automatic logic is_fault(logic we, logic [2:0] funct3, logic [BYTE_OFF_W-1:0] off);
    return (funct3 == F3_BAD) || (we && funct3[2]) || is_misaligned(mem_size_e'(funct3[1:0]), off);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: load extract with sign/zero extension and store read-modify-write merge.
module lsu_align
  import lsu_pkg::*;
(
  input  mem_size_e              size,
  input  logic                   is_unsigned,
  input  logic [BYTE_OFF_W-1:0]  off,
  input  logic [XLEN-1:0]        rd_word,
  input  logic [XLEN-1:0]        wdata,
  output logic [XLEN-1:0]        load_data,
  output logic [XLEN-1:0]        store_word
);

  logic [XLEN-1:0]   shifted_s;
  logic [XLEN-1:0]   lane_data_s;
  logic [XLEN-1:0]   bit_mask_s;
  logic [NBYTES-1:0] size_mask_s;
  logic [NBYTES-1:0] byte_mask_s;

  // Load path: bring the addressed lane to bit 0, then extend from the size's msb.
  always_comb begin
    shifted_s = rd_word >> {off, 3'b000};
    case (size)
      SZ_B:    load_data = {{(XLEN-8){~is_unsigned & shifted_s[7]}},   shifted_s[7:0]};
      SZ_H:    load_data = {{(XLEN-16){~is_unsigned & shifted_s[15]}}, shifted_s[15:0]};
      SZ_W:    load_data = {{(XLEN-32){~is_unsigned & shifted_s[31]}}, shifted_s[31:0]};
      SZ_D:    load_data = shifted_s;
      default: load_data = shifted_s;
    endcase
  end

  // Store path: replace bytes [off, off+size) of the read word with the low store bytes.
  always_comb begin
    case (size)
      SZ_B:    size_mask_s = 8'h01;
      SZ_H:    size_mask_s = 8'h03;
      SZ_W:    size_mask_s = 8'h0F;
      SZ_D:    size_mask_s = 8'hFF;
      default: size_mask_s = 8'h00;
    endcase
    byte_mask_s = size_mask_s << off;
    lane_data_s = wdata << {off, 3'b000};
    for (int i = 0; i < NBYTES; i++) begin
      bit_mask_s[8*i +: 8] = {8{byte_mask_s[i]}};
    end
    store_word = (rd_word & ~bit_mask_s) | (lane_data_s & bit_mask_s);
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one outstanding load/store, sub-word access via read-modify-write,
// misaligned requests answered with a fault without touching memory.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_e            state_r, state_n;
  logic                  lat_we_r, lat_we_n;
  logic [2:0]            lat_f3_r, lat_f3_n;
  logic [BYTE_OFF_W-1:0] lat_off_r, lat_off_n;
  logic [XLEN-1:0]       lat_wdata_r, lat_wdata_n;
  logic                  req_ready_r, resp_valid_r, resp_valid_n, resp_fault_r, resp_fault_n;
  logic                  mem_we_r, mem_we_n;
  logic [XLEN-1:0]       resp_rdata_r, resp_rdata_n;
  logic [XLEN-1:0]       mem_addr_r, mem_addr_n, mem_wdata_r, mem_wdata_n;
  logic [XLEN-1:0]       load_data_s, store_word_s;
  logic                  req_fault_s;

  assign req_fault_s = is_fault(req_we, req_funct3, req_addr[BYTE_OFF_W-1:0]);

  lsu_align u_align (
    .size        (mem_size_e'(lat_f3_r[1:0])),
    .is_unsigned (lat_f3_r[2]),
    .off         (lat_off_r),
    .rd_word     (mem_rdata),
    .wdata       (lat_wdata_r),
    .load_data   (load_data_s),
    .store_word  (store_word_s)
  );

  // Next-state and next-register values for the request FSM.
  always_comb begin
    state_n      = state_r;
    lat_we_n     = lat_we_r;
    lat_f3_n     = lat_f3_r;
    lat_off_n    = lat_off_r;
    lat_wdata_n  = lat_wdata_r;
    resp_valid_n = resp_valid_r;
    resp_fault_n = resp_fault_r;
    resp_rdata_n = resp_rdata_r;
    mem_we_n     = 1'b0;
    mem_addr_n   = mem_addr_r;
    mem_wdata_n  = mem_wdata_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          lat_we_n    = req_we;
          lat_f3_n    = req_funct3;
          lat_off_n   = req_addr[BYTE_OFF_W-1:0];
          lat_wdata_n = req_wdata;
          if (req_fault_s) begin
            resp_valid_n = 1'b1;
            resp_fault_n = 1'b1;
            resp_rdata_n = {XLEN{1'b0}};
            state_n      = RESP;
          end else begin
            mem_addr_n = {req_addr[XLEN-1:BYTE_OFF_W], {BYTE_OFF_W{1'b0}}};
            state_n    = ACCESS;
          end
        end else begin
          state_n = IDLE;
        end
      end
      ACCESS: begin
        if (lat_we_r) begin
          mem_wdata_n = store_word_s;
          mem_we_n    = 1'b1;
          state_n     = WRITE;
        end else begin
          resp_valid_n = 1'b1;
          resp_fault_n = 1'b0;
          resp_rdata_n = load_data_s;
          state_n      = RESP;
        end
      end
      WRITE: begin
        resp_valid_n = 1'b1;
        resp_fault_n = 1'b0;
        resp_rdata_n = {XLEN{1'b0}};
        state_n      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_n = 1'b0;
          state_n      = IDLE;
        end else begin
          state_n = RESP;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      lat_we_r     <= 1'b0;
      lat_f3_r     <= 3'b000;
      lat_off_r    <= {BYTE_OFF_W{1'b0}};
      lat_wdata_r  <= {XLEN{1'b0}};
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_fault_r <= 1'b0;
      resp_rdata_r <= {XLEN{1'b0}};
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {XLEN{1'b0}};
      mem_wdata_r  <= {XLEN{1'b0}};
    end else begin
      state_r      <= state_n;
      lat_we_r     <= lat_we_n;
      lat_f3_r     <= lat_f3_n;
      lat_off_r    <= lat_off_n;
      lat_wdata_r  <= lat_wdata_n;
      req_ready_r  <= (state_n == IDLE);
      resp_valid_r <= resp_valid_n;
      resp_fault_r <= resp_fault_n;
      resp_rdata_r <= resp_rdata_n;
      mem_we_r     <= mem_we_n;
      mem_addr_r   <= mem_addr_n;
      mem_wdata_r  <= mem_wdata_n;
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_fault = resp_fault_r;
  assign resp_rdata = resp_rdata_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: directed vector table, hand-written hold/reset sequences, and random
// requests checked against a byte-array memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
  logic        resp_valid, resp_ready = 1'b0, resp_fault, mem_we;
  logic [63:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [63:0] mem [32];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_idx = 5'd0;
  logic [63:0] pl_data = 64'd0;
  logic [7:0]  ref_bytes [256];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory: 32 words, combinational read, write on clock edge; bench preload port muxed in.
  assign mem_rdata = mem[mem_addr[7:3]];
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_we) mem[mem_addr[7:3]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [63:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx[4:0]; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wdata, output logic [63:0] rdata, output logic fault,
                        output int lat, output int wecnt);
    lat = 0; wecnt = 0; rdata = 64'd0; fault = 1'b0;
    @(negedge clk);
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_we) wecnt++;
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; fault = resp_fault;
        break;
      end
    end
    if (lat == 0) chk("resp_timeout", 64'd0, 64'd1);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  function automatic logic [63:0] ref_load(input logic [2:0] f3, input int addr);
    int n = 1 << f3[1:0];
    logic [63:0] v = 64'd0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_bytes[addr + i]) << (8 * i));
    if (n < 8 && !f3[2] && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v;
  endfunction

  function automatic logic [63:0] ref_word(input int idx);
    logic [63:0] v = 64'd0;
    for (int i = 0; i < 8; i++) v = v | (64'(ref_bytes[idx*8 + i]) << (8 * i));
    return v;
  endfunction

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
    logic [63:0] exp_w0;
  } vec_t;

  function automatic vec_t mkv(logic we, logic [2:0] f3, logic [63:0] addr, logic [63:0] wdata,
                               logic [63:0] er, logic ef, int el, logic [63:0] ew);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = er; v.exp_fault = ef; v.exp_lat = el; v.exp_w0 = ew;
    return v;
  endfunction

  initial begin
    vec_t        vecs [15];
    logic [63:0] rd, saved, exp;
    logic        flt, we, efault;
    logic [2:0]  f3;
    int          lat, wecnt, addr, n, wecnt_rst;

    vecs[0]  = mkv(1'b0, 3'b000, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FF88, 1'b0, 2, 64'h8877_6655_4433_2211);
    vecs[1]  = mkv(1'b0, 3'b101, 64'd6, 64'd0, 64'h0000_0000_0000_8877, 1'b0, 2, 64'h8877_6655_4433_2211);
    vecs[2]  = mkv(1'b0, 3'b010, 64'd4, 64'd0, 64'hFFFF_FFFF_8877_6655, 1'b0, 2, 64'h8877_6655_4433_2211);
    vecs[3]  = mkv(1'b0, 3'b100, 64'd7, 64'd0, 64'h0000_0000_0000_0088, 1'b0, 2, 64'h8877_6655_4433_2211);
    vecs[4]  = mkv(1'b1, 3'b000, 64'd3, 64'hAB, 64'd0, 1'b0, 3, 64'h8877_6655_AB33_2211);
    vecs[5]  = mkv(1'b0, 3'b010, 64'd2, 64'd0, 64'd0, 1'b1, 1, 64'h8877_6655_AB33_2211);
    vecs[6]  = mkv(1'b0, 3'b011, 64'd0, 64'd0, 64'h8877_6655_AB33_2211, 1'b0, 2, 64'h8877_6655_AB33_2211);
    vecs[7]  = mkv(1'b1, 3'b001, 64'd6, 64'hFFFF_FFFF_FFFF_1234, 64'd0, 1'b0, 3, 64'h1234_6655_AB33_2211);
    vecs[8]  = mkv(1'b1, 3'b100, 64'd0, 64'h55, 64'd0, 1'b1, 1, 64'h1234_6655_AB33_2211);
    vecs[9]  = mkv(1'b0, 3'b111, 64'd0, 64'd0, 64'd0, 1'b1, 1, 64'h1234_6655_AB33_2211);
    vecs[10] = mkv(1'b0, 3'b001, 64'd1, 64'd0, 64'd0, 1'b1, 1, 64'h1234_6655_AB33_2211);
    vecs[11] = mkv(1'b0, 3'b110, 64'd0, 64'd0, 64'h0000_0000_AB33_2211, 1'b0, 2, 64'h1234_6655_AB33_2211);
    vecs[12] = mkv(1'b0, 3'b001, 64'd2, 64'd0, 64'hFFFF_FFFF_FFFF_AB33, 1'b0, 2, 64'h1234_6655_AB33_2211);
    vecs[13] = mkv(1'b1, 3'b011, 64'd0, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0, 3, 64'h0123_4567_89AB_CDEF);
    vecs[14] = mkv(1'b0, 3'b111, 64'd8, 64'd0, 64'd0, 1'b1, 1, 64'h0123_4567_89AB_CDEF);

    // Reset values
    #12;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_resp_fault", {63'd0, resp_fault}, 64'd0);
    chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) preload(i, 64'h1111_0000_0000_0000 + 64'(i));
    preload(0, 64'h8877_6655_4433_2211);

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, flt, lat, wecnt);
      chk($sformatf("vec%0d_fault", i), {63'd0, flt}, {63'd0, vecs[i].exp_fault});
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_mem_we_cycles", i), 64'(wecnt),
          (vecs[i].we && !vecs[i].exp_fault) ? 64'd1 : 64'd0);
      chk($sformatf("vec%0d_word0", i), mem[0], vecs[i].exp_w0);
    end

    // Response held while resp_ready low; a new request meanwhile is ignored
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 64'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (resp_valid) lat = c;
    end
    chk("hold_latency", 64'(lat), 64'd2);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 64'd0; req_wdata = 64'hFF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_resp_valid", {63'd0, resp_valid}, 64'd1);
      chk("hold_resp_rdata", resp_rdata, 64'h0123_4567_89AB_CDEF);
      chk("hold_req_ready", {63'd0, req_ready}, 64'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    wecnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid || mem_we) wecnt++;
    end
    chk("ignored_req_no_activity", 64'(wecnt), 64'd0);
    chk("ignored_req_word0", mem[0], 64'h0123_4567_89AB_CDEF);
    chk("ignored_req_ready", {63'd0, req_ready}, 64'd1);

    // Random requests against the byte-array model
    for (int i = 0; i < 32; i++) begin
      saved = {$urandom, $urandom};
      preload(i, saved);
      for (int b = 0; b < 8; b++) ref_bytes[i*8 + b] = saved[8*b +: 8];
    end
    for (int k = 0; k < 300; k++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom_range(0, 255);
      n = 1 << f3[1:0];
      if ($urandom_range(0, 1) == 1) addr = addr - (addr % n);
      saved = {$urandom, $urandom};
      efault = (f3 == 3'b111) || (we && f3[2]) || (addr % n != 0);
      exp = (efault || we) ? 64'd0 : ref_load(f3, addr);
      do_req(we, f3, 64'(addr), saved, rd, flt, lat, wecnt);
      if (!efault && we) begin
        for (int b = 0; b < n; b++) ref_bytes[addr + b] = saved[8*b +: 8];
      end
      chk("rnd_fault", {63'd0, flt}, {63'd0, efault});
      chk("rnd_rdata", rd, exp);
      chk("rnd_latency", 64'(lat), efault ? 64'd1 : (we ? 64'd3 : 64'd2));
      chk("rnd_mem_we_cycles", 64'(wecnt), (we && !efault) ? 64'd1 : 64'd0);
      chk("rnd_word", mem[addr / 8], ref_word(addr / 8));
    end

    // Reset while a store sits in ACCESS: no write may reach memory
    saved = mem[1];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b011; req_addr = 64'd8; req_wdata = ~saved;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("midrst_resp_rdata", resp_rdata, 64'd0);
    chk("midrst_resp_fault", {63'd0, resp_fault}, 64'd0);
    chk("midrst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("midrst_mem_addr", mem_addr, 64'd0);
    chk("midrst_mem_wdata", mem_wdata, 64'd0);
    wecnt_rst = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_we) wecnt_rst++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_we || resp_valid) wecnt_rst++;
    end
    chk("midrst_no_activity", 64'(wecnt_rst), 64'd0);
    chk("midrst_word1", mem[1], saved);
    chk("midrst_ready_after", {63'd0, req_ready}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
